// File: rtl/chardisp_vram_ctrl.sv
// VRAM port-A controller: bus access always wins, the fill/scroll engine uses idle port cycles.
// Build option: define CHARDISP_SCROLL_EN to include the one-row scroll-up operation.
module chardisp_vram_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 50,
  parameter int AW   = 12,
  parameter int DW   = 24
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [15:0]   WRADDR,
  input  logic [3:0]    BYTEEN,
  input  logic          WREN,
  input  logic [31:0]   WRDATA,
  input  logic [15:0]   RDADDR,
  input  logic          RDEN,
  output logic [31:0]   RDDATA,
  input  logic          CMD_START,
  input  logic          CMD_OP,
  input  logic [DW-1:0] CMD_FILL,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] VRAM_ADDR,
  output logic [2:0]    VRAM_WEA,
  output logic [DW-1:0] VRAM_DIN,
  input  logic [DW-1:0] VRAM_DOUT
);

  localparam logic [AW-1:0] A_LAST   = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] A_SCR_END = AW'(COLS * (ROWS - 1) - 1);
  localparam logic [AW-1:0] A_LASTROW = AW'(COLS * (ROWS - 1));
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);

`ifdef CHARDISP_SCROLL_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SCR_RD, S_SCR_CAP, S_SCR_WR, S_SCR_FILL, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_FIN} state_t;
`endif

  state_t        state, state_nxt;
  logic [AW-1:0] a, a_nxt;
  logic [DW-1:0] fill_q, fill_nxt;
  logic          eng_we, eng_rd, eng_gnt;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_din;
`ifdef CHARDISP_SCROLL_EN
  logic [DW-1:0] hold, hold_nxt;
`endif

  // The engine is also locked out while RST is high so a reset stops writes immediately.
  assign eng_gnt = !(WREN || RDEN) && !RST;

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    fill_nxt  = fill_q;
    eng_we    = 1'b0;
    eng_rd    = 1'b0;
    eng_addr  = a;
    eng_din   = fill_q;
`ifdef CHARDISP_SCROLL_EN
    hold_nxt  = hold;
`endif
    case (state)
      S_IDLE: begin
        if (CMD_START) begin
          fill_nxt = CMD_FILL;
          a_nxt    = '0;
`ifdef CHARDISP_SCROLL_EN
          state_nxt = CMD_OP ? S_SCR_RD : S_FILL;
`else
          state_nxt = CMD_OP ? S_FIN : S_FILL;
`endif
        end
      end
      S_FILL: begin
        eng_we = 1'b1;
        if (eng_gnt) begin
          if (a == A_LAST) state_nxt = S_FIN;
          else             a_nxt = a + 1'b1;
        end
      end
`ifdef CHARDISP_SCROLL_EN
      S_SCR_RD: begin
        eng_rd   = 1'b1;
        eng_addr = a + COLS_A;
        if (eng_gnt) state_nxt = S_SCR_CAP;
      end
      S_SCR_CAP: begin
        hold_nxt  = VRAM_DOUT;
        state_nxt = S_SCR_WR;
      end
      S_SCR_WR: begin
        eng_we  = 1'b1;
        eng_din = hold;
        if (eng_gnt) begin
          if (a == A_SCR_END) begin
            a_nxt     = A_LASTROW;
            state_nxt = S_SCR_FILL;
          end else begin
            a_nxt     = a + 1'b1;
            state_nxt = S_SCR_RD;
          end
        end
      end
      S_SCR_FILL: begin
        eng_we = 1'b1;
        if (eng_gnt) begin
          if (a == A_LAST) state_nxt = S_FIN;
          else             a_nxt = a + 1'b1;
        end
      end
`endif
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    VRAM_ADDR = '0;
    VRAM_WEA  = 3'b000;
    VRAM_DIN  = WRDATA[DW-1:0];
    if (RDEN) begin
      VRAM_ADDR = RDADDR[AW+1:2];
    end else if (WREN) begin
      VRAM_ADDR = WRADDR[AW+1:2];
      VRAM_WEA  = BYTEEN[2:0];
    end else if (eng_gnt && eng_we) begin
      VRAM_ADDR = eng_addr;
      VRAM_WEA  = 3'b111;
      VRAM_DIN  = eng_din;
    end else if (eng_gnt && eng_rd) begin
      VRAM_ADDR = eng_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      a      <= '0;
      fill_q <= '0;
`ifdef CHARDISP_SCROLL_EN
      hold   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      a      <= a_nxt;
      fill_q <= fill_nxt;
`ifdef CHARDISP_SCROLL_EN
      hold   <= hold_nxt;
`endif
    end
  end

  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_FIN);
  assign RDDATA = {{(32-DW){1'b0}}, VRAM_DOUT};

  logic unused_bits;
  assign unused_bits = &{1'b0, WRADDR[15:AW+2], WRADDR[1:0], RDADDR[15:AW+2], RDADDR[1:0],
                         BYTEEN[3], WRDATA[31:DW]};

endmodule

// File: tb/tb_chardisp_vram_ctrl.sv
// Bench for chardisp_vram_ctrl: bus-mux vector table plus fill/scroll runs under random bus
// traffic, checked cycle by cycle against an operation-list reference model and a VRAM image.
module tb_chardisp_vram_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 50;
  localparam int NW   = COLS * ROWS;
  localparam int NSCR = NW - COLS;
`ifdef CHARDISP_SCROLL_EN
  localparam int SCROLL_OPS = 3 * NSCR + COLS;
`else
  localparam int SCROLL_OPS = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic        WREN, RDEN;
  logic [31:0] WRDATA, RDDATA;
  logic        CMD_START, CMD_OP;
  logic [23:0] CMD_FILL;
  logic        BUSY, DONE;
  logic [11:0] VRAM_ADDR;
  logic [2:0]  VRAM_WEA;
  logic [23:0] VRAM_DIN, VRAM_DOUT;

  always #5 CLK = ~CLK;

  chardisp_vram_ctrl dut (
    .CLK(CLK), .RST(RST), .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WRDATA(WRDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDDATA(RDDATA), .CMD_START(CMD_START), .CMD_OP(CMD_OP),
    .CMD_FILL(CMD_FILL), .BUSY(BUSY), .DONE(DONE), .VRAM_ADDR(VRAM_ADDR), .VRAM_WEA(VRAM_WEA),
    .VRAM_DIN(VRAM_DIN), .VRAM_DOUT(VRAM_DOUT)
  );

  // VRAM port A: byte-enabled write, registered read
  logic [23:0] vram [0:4095];
  logic        preload_req = 1'b0;
  always @(posedge CLK) begin
    if (preload_req) begin
      for (int i = 0; i < 4096; i++) vram[i] <= 24'(i);
    end else begin
      for (int b = 0; b < 3; b++)
        if (VRAM_WEA[b]) vram[VRAM_ADDR][8*b +: 8] <= VRAM_DIN[8*b +: 8];
    end
    VRAM_DOUT <= vram[VRAM_ADDR];
  end

  int total = 0;
  int bad   = 0;

  logic [23:0] ref_mem [0:4095];
  bit          m_run = 0;
  bit          m_scr = 0;
  int          m_p, m_total;
  logic [23:0] m_fill, m_hold, m_rdval;
  int          cyc, stalls, last_done, eng_wr_cnt;
  bit          rd_pend = 0;
  logic [23:0] rd_exp;

  typedef struct {
    logic        wren, rden;
    logic [15:0] wraddr;
    logic [3:0]  byteen;
    logic [31:0] wrdata;
    logic [15:0] rdaddr;
    logic [11:0] e_addr;
    logic [2:0]  e_wea;
    logic [23:0] e_din;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Operation list of a command: kind 0 = write fill word, 1 = read source, 2 = capture, 3 = write held word
  function automatic void op_info(input int p, input bit scr, output int kind, output int addr);
    kind = 0;
    addr = p;
    if (scr) begin
      if (p < 3 * NSCR) begin
        addr = p / 3;
        case (p % 3)
          0:       begin kind = 1; addr = p / 3 + COLS; end
          1:       kind = 2;
          default: kind = 3;
        endcase
      end else begin
        addr = NSCR + (p - 3 * NSCR);
      end
    end
  endfunction

  // One clock cycle: inputs already driven; check at negedge, then advance the model.
  task automatic tick();
    logic [11:0] e_addr;
    logic [2:0]  e_wea;
    logic [23:0] e_din;
    int kind, oaddr;
    bit eng_go;
    @(negedge CLK);
    kind = -1; oaddr = 0; eng_go = 0;
    if (m_run && m_p < m_total) op_info(m_p, m_scr, kind, oaddr);
    e_addr = '0; e_wea = '0; e_din = '0;
    if (RDEN) e_addr = RDADDR[13:2];
    else if (WREN) begin
      e_addr = WRADDR[13:2]; e_wea = BYTEEN[2:0]; e_din = WRDATA[23:0];
    end else if (!RST && kind >= 0 && kind != 2) begin
      eng_go = 1;
      e_addr = 12'(oaddr);
      if (kind != 1) begin
        e_wea = 3'b111;
        e_din = (kind == 0) ? m_fill : m_hold;
      end
    end
    check("busy_done", {BUSY, DONE}, {m_run, m_run && (m_p == m_total)});
    check("port", {VRAM_ADDR, VRAM_WEA}, {e_addr, e_wea});
    if (e_wea != 0) check("din", VRAM_DIN, e_din);
    if (rd_pend) check("rddata", RDDATA, {8'h00, rd_exp});
    if (DONE) last_done = cyc;
    if (VRAM_WEA != 0 && !WREN) eng_wr_cnt++;
    if (!RST && kind >= 0 && kind != 2 && (WREN || RDEN)) stalls++;

    rd_pend = RDEN;
    if (RDEN) rd_exp = ref_mem[RDADDR[13:2]];
    else if (WREN)
      for (int b = 0; b < 3; b++)
        if (BYTEEN[b]) ref_mem[WRADDR[13:2]][8*b +: 8] = WRDATA[8*b +: 8];
    if (RST) m_run = 0;
    else if (m_run) begin
      if (m_p == m_total) m_run = 0;
      else if (kind == 2) begin m_hold = m_rdval; m_p++; end
      else if (eng_go) begin
        if (kind == 1) m_rdval = ref_mem[oaddr];
        else ref_mem[oaddr] = (kind == 0) ? m_fill : m_hold;
        m_p++;
      end
    end else if (CMD_START) begin
      m_run = 1; m_p = 0; m_fill = CMD_FILL; m_scr = CMD_OP;
      m_total = CMD_OP ? SCROLL_OPS : NW;
    end
    if (preload_req) for (int i = 0; i < 4096; i++) ref_mem[i] = 24'(i);
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    WREN = 0; RDEN = 0; WRADDR = '0; RDADDR = '0; BYTEEN = '0; WRDATA = '0;
  endtask

  // mode 0: quiet, 1: full-word write every 4th cycle, 2: random reads/writes
  task automatic drive_bus(input int mode, input int i);
    int r;
    idle_bus();
    r = $urandom_range(0, 9);
    if (mode == 1 && (i % 4) == 3) begin
      WREN = 1; BYTEEN = 4'hF; WRDATA = $urandom;
      WRADDR = {2'($urandom), 12'($urandom_range(0, NW - 1)), 2'($urandom)};
    end else if (mode == 2 && r < 2) begin
      RDEN = 1;
      RDADDR = {2'($urandom), 12'($urandom_range(0, NW - 1)), 2'($urandom)};
      WREN = $urandom_range(0, 1);
    end else if (mode == 2 && r < 4) begin
      WREN = 1; BYTEEN = 4'($urandom); WRDATA = $urandom;
      WRADDR = {2'($urandom), 12'($urandom_range(0, NW - 1)), 2'($urandom)};
    end
  endtask

  task automatic preload();
    idle_bus();
    preload_req = 1;
    tick();
    preload_req = 0;
  endtask

  task automatic run_cmd(input bit op, input logic [23:0] fw, input int mode, input int nominal,
                         input bit poke);
    idle_bus();
    CMD_START = 1; CMD_OP = op; CMD_FILL = fw;
    cyc = 0; stalls = 0; last_done = -1; eng_wr_cnt = 0;
    tick();
    CMD_START = 0;
    for (int i = 1; i < 20000 && m_run; i++) begin
      drive_bus(mode, i);
      if (poke && i == 50) begin CMD_START = 1; CMD_OP = ~op; CMD_FILL = 24'h123456; end
      tick();
      CMD_START = 0;
    end
    idle_bus();
    tick();
    check("finished", m_run, 0);
    check("done_cycle", 64'(last_done), 64'(nominal + stalls));
  endtask

  task automatic mem_compare(input string nm);
    int nb = 0;
    for (int i = 0; i < NW; i++) if (vram[i] !== ref_mem[i]) nb++;
    check(nm, nb, 0);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,         16'h0000, 12'h000, 3'b000, 24'h000000};
    vt[1] = '{1'b1, 1'b0, 16'h0008, 4'hF, 32'h00000F41,  16'h0000, 12'h002, 3'b111, 24'h000F41};
    vt[2] = '{1'b0, 1'b1, 16'h0000, 4'h0, 32'h0,         16'h0008, 12'h002, 3'b000, 24'h000000};
    vt[3] = '{1'b1, 1'b0, 16'hC010, 4'h5, 32'hAABBCCDD,  16'h0000, 12'h004, 3'b101, 24'hBBCCDD};
    vt[4] = '{1'b1, 1'b1, 16'h0004, 4'hF, 32'h11223344,  16'h3E7C, 12'hF9F, 3'b000, 24'h000000};
    vt[5] = '{1'b1, 1'b0, 16'h3E7F, 4'h8, 32'h55667788,  16'h0000, 12'hF9F, 3'b000, 24'h000000};

    RST = 1; CMD_START = 0; CMD_OP = 0; CMD_FILL = '0; cyc = 0;
    idle_bus();
    repeat (3) @(posedge CLK);
    #1;
    tick();
    RST = 0;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    preload();

    foreach (vt[k]) begin
      WREN = vt[k].wren; RDEN = vt[k].rden; WRADDR = vt[k].wraddr; BYTEEN = vt[k].byteen;
      WRDATA = vt[k].wrdata; RDADDR = vt[k].rdaddr;
      #2;
      check($sformatf("vec%0d_port", k), {VRAM_ADDR, VRAM_WEA}, {vt[k].e_addr, vt[k].e_wea});
      if (vt[k].e_wea != 0) check($sformatf("vec%0d_din", k), VRAM_DIN, vt[k].e_din);
      tick();
    end
    idle_bus();
    RDEN = 1; RDADDR = 16'h0008;
    tick();
    idle_bus();
    check("rd_0x8", RDDATA, 32'h00000F41);
    tick();

    // uncontended fill with an ignored second command at cycle 50
    run_cmd(1'b0, 24'h0FFF20, 0, 4001, 1'b1);
    check("fill_done_4001", 64'(last_done), 64'd4001);
    begin
      int nb = 0;
      for (int i = 0; i < NW; i++) if (vram[i] !== 24'h0FFF20) nb++;
      check("fill_const", nb, 0);
    end

    run_cmd(1'b0, 24'h0A0B0C, 1, 4001, 1'b0);
    mem_compare("fill_every4_mem");

`ifdef CHARDISP_SCROLL_EN
    preload();
    run_cmd(1'b1, 24'h0ABC55, 0, 11841, 1'b0);
    check("scroll_done_11841", 64'(last_done), 64'd11841);
    begin
      int nb = 0;
      for (int i = 0; i < NSCR; i++) if (vram[i] !== 24'(i + COLS)) nb++;
      for (int i = NSCR; i < NW; i++) if (vram[i] !== 24'h0ABC55) nb++;
      check("scroll_const", nb, 0);
    end
    preload();
    run_cmd(1'b1, 24'h00F00D, 2, 11841, 1'b0);
    mem_compare("scroll_random_mem");
`else
    run_cmd(1'b1, 24'h00F00D, 2, 1, 1'b0);
    check("noscroll_done_1", 64'(last_done), 64'd1);
    check("noscroll_no_writes", eng_wr_cnt, 0);
`endif

    run_cmd(1'b0, 24'h0C0FFE, 2, 4001, 1'b0);
    mem_compare("fill_random_mem");

    // reset in the cycle that would write word 100
    preload();
    idle_bus();
    CMD_START = 1; CMD_OP = 0; CMD_FILL = 24'hABCDEF; cyc = 0;
    tick();
    CMD_START = 0;
    for (int i = 1; i <= 100; i++) tick();
    RST = 1;
    tick();
    RST = 0;
    eng_wr_cnt = 0;
    repeat (5) tick();
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_no_writes", eng_wr_cnt, 0);
    begin
      int nb = 0;
      for (int i = 0; i < NW; i++)
        if (vram[i] !== ((i < 100) ? 24'hABCDEF : 24'(i))) nb++;
      check("rst_mid_mem", nb, 0);
    end
    mem_compare("rst_mid_model_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
